// File: rtl/matrix_pkg.sv
// Shared types and defaults for the 4x4 matrix serializer.
// Saturating narrowing is selected with MATRIX_SER_SAT_EN (see fxp_narrow).
package matrix_pkg;

  localparam int unsigned W_DEF       = 12;
  localparam int unsigned FXP_MUL_DEF = 1024;
  localparam int unsigned FRAC_DEF    = $clog2(FXP_MUL_DEF);

  typedef logic signed [W_DEF-1:0]   elem_t;
  typedef logic signed [2*W_DEF-1:0] acc_t;
  typedef logic [3:0][2*W_DEF-1:0]   col_t;

  typedef enum logic {
    IDLE,
    STREAM
  } ser_state_e;

endpackage

// File: rtl/matrix_4x4_ser_fxp_narrow.sv
// Fixed-point narrowing: arithmetic shift right by FRAC, then fit to W bits.
// MATRIX_SER_SAT_EN defined: clamp to the W-bit signed range; else two's-complement wrap.
module fxp_narrow
  import matrix_pkg::*;
#(
  parameter int unsigned W    = W_DEF,
  parameter int unsigned FRAC = FRAC_DEF
) (
  input  logic [2*W-1:0] acc_i,
  output logic [W-1:0]   elem_o
);

  logic signed [2*W-1:0] shifted;

`ifdef MATRIX_SER_SAT_EN
  localparam logic signed [2*W-1:0] SAT_MAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] SAT_MIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};
`endif

  always_comb begin
    shifted = $signed(acc_i) >>> FRAC;
`ifdef MATRIX_SER_SAT_EN
    if (shifted > SAT_MAX) begin
      elem_o = {1'b0, {(W-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      elem_o = {1'b1, {(W-1){1'b0}}};
    end else begin
      elem_o = W'(shifted);
    end
`else
    elem_o = W'(shifted);
`endif
  end

endmodule

// File: rtl/matrix_4x4_ser.sv
// Serializes a parallel 4x4 fixed-point matrix into 16 column-major W-bit beats.
// Narrowing behaviour depends on MATRIX_SER_SAT_EN (saturate vs wrap).
module matrix_4x4_ser
  import matrix_pkg::*;
#(
  parameter int unsigned W       = W_DEF,
  parameter int unsigned FXP_MUL = FXP_MUL_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  output logic                 ready_out,
  input  logic [3:0][2*W-1:0]  c1,
  input  logic [3:0][2*W-1:0]  c2,
  input  logic [3:0][2*W-1:0]  c3,
  input  logic [3:0][2*W-1:0]  c4,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic [W-1:0]         c_out,
  output logic                 last_out
);

  localparam int unsigned FRAC = $clog2(FXP_MUL);

  ser_state_e             state_q, state_d;
  logic [3:0]             idx_q, idx_d;
  logic [15:0][2*W-1:0]   mat_q, mat_d;
  logic [W-1:0]           c_out_q, c_out_d;
  logic                   valid_q, valid_d;
  logic                   last_q, last_d;
  logic                   ready_q, ready_d;

  logic [2*W-1:0]         conv_in;
  logic [W-1:0]           conv_out;

  // In IDLE the first beat comes straight from the input so it is ready on the capture edge.
  assign conv_in = (state_q == IDLE) ? c1[0] : mat_q[idx_q];

  fxp_narrow #(
    .W    (W),
    .FRAC (FRAC)
  ) u_narrow (
    .acc_i  (conv_in),
    .elem_o (conv_out)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mat_d   = mat_q;
    c_out_d = c_out_q;
    valid_d = valid_q;
    last_d  = last_q;
    ready_d = ready_q;

    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        // ready_q gates capture so the first edge after reset release only raises ready.
        if (ready_q && valid_in) begin
          mat_d   = {c4, c3, c2, c1};
          c_out_d = conv_out;
          valid_d = 1'b1;
          last_d  = 1'b0;
          idx_d   = 4'd1;
          ready_d = 1'b0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (valid_q && ready_in) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            ready_d = 1'b1;
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            c_out_d = conv_out;
            last_d  = (idx_q == 4'd15);
            idx_d   = idx_q + 4'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mat_q   <= '0;
      c_out_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mat_q   <= mat_d;
      c_out_q <= c_out_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      ready_q <= ready_d;
    end
  end

  assign ready_out = ready_q;
  assign valid_out = valid_q;
  assign c_out     = c_out_q;
  assign last_out  = last_q;

endmodule

// File: tb/tb_matrix_4x4_ser.sv
// Self-checking bench for matrix_4x4_ser against a floor-division reference model.
module tb_matrix_4x4_ser;

  localparam int W = 12;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                valid_in = 1'b0;
  logic                ready_in = 1'b0;
  logic                ready_out, valid_out, last_out;
  logic [3:0][2*W-1:0] c1 = '0, c2 = '0, c3 = '0, c4 = '0;
  logic [W-1:0]        c_out;

  int checks = 0;
  int errors = 0;
  int cycles_used;

  // mat[k] is the element streamed on beat k: column k/4, row k%4
  logic [2*W-1:0] mat [16];
  logic [W-1:0]   got [16];

  always #5 clk = ~clk;

  matrix_4x4_ser #(.W(12), .FXP_MUL(1024)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .c1        (c1),
    .c2        (c2),
    .c3        (c3),
    .c4        (c4),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .c_out     (c_out),
    .last_out  (last_out)
  );

  function automatic logic [W-1:0] model_conv(input logic [2*W-1:0] raw);
    longint v, q;
    v = longint'($signed(raw));
    q = v / 1024;
    if (v < 0 && (v % 1024) != 0) q = q - 1;
`ifdef MATRIX_SER_SAT_EN
    if (q > 2047)  q = 2047;
    if (q < -2048) q = -2048;
`endif
    return q[W-1:0];
  endfunction

  task automatic load_inputs();
    for (int r = 0; r < 4; r++) begin
      c1[r] = mat[r];
      c2[r] = mat[4+r];
      c3[r] = mat[8+r];
      c4[r] = mat[12+r];
    end
  endtask

  task automatic rand_mat();
    logic [31:0] tmp;
    for (int k = 0; k < 16; k++) begin
      tmp = $urandom;
      mat[k] = (k % 2 == 1) ? {{3{tmp[20]}}, tmp[20:0]} : tmp[23:0];
    end
  endtask

  // bp: 0 = ready_in always high, 1 = random, 2 = low for stream cycles 3..7
  task automatic run_matrix(input int bp, input bit hold_valid);
    logic [W-1:0] exp_e [16];
    int beat, cyc, wait_n;
    bit rdy;
    for (int k = 0; k < 16; k++) exp_e[k] = model_conv(mat[k]);
    wait_n = 0;
    while (ready_out !== 1'b1 && wait_n < 50) begin
      @(posedge clk); #1;
      wait_n++;
    end
    checks++;
    if (ready_out !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait: ready_out=%b required 1", ready_out);
    end
    load_inputs();
    valid_in = 1'b1;
    ready_in = 1'b0;
    @(posedge clk); #1;
    if (!hold_valid) valid_in = 1'b0;
    cyc  = 1;
    beat = 0;
    while (beat < 16 && cyc < 200) begin
      if (hold_valid) begin
        for (int r = 0; r < 4; r++) begin
          c1[r] = 24'($urandom);
          c2[r] = 24'($urandom);
          c3[r] = 24'($urandom);
          c4[r] = 24'($urandom);
        end
      end
      case (bp)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = !(cyc >= 3 && cyc <= 7);
      endcase
      ready_in = rdy;
      checks++;
      if (valid_out !== 1'b1 || ready_out !== 1'b0 || c_out !== exp_e[beat] ||
          last_out !== (beat == 15)) begin
        errors++;
        $display("FAIL beat%0d: valid=%b ready_out=%b c_out=%h last=%b required valid=1 ready_out=0 c_out=%h last=%b",
                 beat, valid_out, ready_out, c_out, last_out, exp_e[beat], (beat == 15));
      end
      got[beat] = c_out;
      if (rdy) beat++;
      @(posedge clk); #1;
      cyc++;
    end
    valid_in    = 1'b0;
    ready_in    = 1'b0;
    cycles_used = cyc;
    checks++;
    if (beat != 16 || valid_out !== 1'b0 || last_out !== 1'b0 || ready_out !== 1'b1) begin
      errors++;
      $display("FAIL end_of_matrix: beats=%0d valid=%b last=%b ready_out=%b required beats=16 valid=0 last=0 ready_out=1",
               beat, valid_out, last_out, ready_out);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (ready_out !== 1'b0 || valid_out !== 1'b0 || last_out !== 1'b0 || c_out !== '0) begin
      errors++;
      $display("FAIL reset_state: ready=%b valid=%b last=%b c_out=%h required 0 0 0 000",
               ready_out, valid_out, last_out, c_out);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rand_mat();
    load_inputs();
    valid_in = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b valid=%b required ready=1 valid=0", ready_out, valid_out);
    end
    valid_in = 1'b0;
  endtask

  task automatic test_identity();
    for (int k = 0; k < 16; k++) mat[k] = 24'((k + 1) << 20);
    run_matrix(0, 1'b0);
    checks++;
    if (cycles_used != 17) begin
      errors++;
      $display("FAIL identity_period: cycles=%0d required 17", cycles_used);
    end
    checks++;
    if (got[0] !== 12'h400) begin
      errors++;
      $display("FAIL identity_first: c_out=%h required 400", got[0]);
    end
  endtask

  task automatic test_negative();
    rand_mat();
    mat[0] = 24'hF80000;
    run_matrix(0, 1'b0);
    checks++;
    if (got[0] !== 12'hE00) begin
      errors++;
      $display("FAIL negative_half: c_out=%h required E00", got[0]);
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] exp_pos, exp_neg;
`ifdef MATRIX_SER_SAT_EN
    exp_pos = 12'h7FF;
    exp_neg = 12'h800;
`else
    exp_pos = 12'h000;
    exp_neg = 12'h000;
`endif
    rand_mat();
    mat[0] = 24'h400000;
    mat[1] = 24'hC00000;
    run_matrix(0, 1'b0);
    checks++;
    if (got[0] !== exp_pos) begin
      errors++;
      $display("FAIL overflow_pos: c_out=%h required %h", got[0], exp_pos);
    end
    checks++;
    if (got[1] !== exp_neg) begin
      errors++;
      $display("FAIL overflow_neg: c_out=%h required %h", got[1], exp_neg);
    end
  endtask

  task automatic test_backpressure();
    rand_mat();
    run_matrix(2, 1'b0);
    checks++;
    if (cycles_used != 22) begin
      errors++;
      $display("FAIL bp_period: cycles=%0d required 22", cycles_used);
    end
    for (int i = 0; i < 3; i++) begin
      rand_mat();
      run_matrix(1, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      rand_mat();
      run_matrix(0, 1'b0);
      checks++;
      if (cycles_used != 17) begin
        errors++;
        $display("FAIL b2b_period%0d: cycles=%0d required 17", i, cycles_used);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [W-1:0] exp5;
    rand_mat();
    exp5 = model_conv(mat[5]);
    load_inputs();
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    ready_in = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    ready_in = 1'b0;
    checks++;
    if (valid_out !== 1'b1 || c_out !== exp5) begin
      errors++;
      $display("FAIL mid_beat5: valid=%b c_out=%h required valid=1 c_out=%h", valid_out, c_out, exp5);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0 || ready_out !== 1'b0 || last_out !== 1'b0 || c_out !== '0) begin
      errors++;
      $display("FAIL mid_reset_async: valid=%b ready=%b last=%b c_out=%h required 0 0 0 000",
               valid_out, ready_out, last_out, c_out);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_release: ready=%b valid=%b required ready=1 valid=0", ready_out, valid_out);
    end
    rand_mat();
    run_matrix(0, 1'b0);
    checks++;
    if (cycles_used != 17) begin
      errors++;
      $display("FAIL mid_restream_period: cycles=%0d required 17", cycles_used);
    end
  endtask

  task automatic test_valid_in_stream();
    for (int i = 0; i < 2; i++) begin
      rand_mat();
      run_matrix(1, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_negative();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    test_valid_in_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_4x4_ser.md
MATRIX_4X4_SER -- requirements
Module: matrix_4x4_ser

Interface
REQ-001 Parameter W, default 12, output element width, signed fixed-point 12:10.
REQ-002 Parameter FXP_MUL, default 1024, fixed-point scale; FRAC = log2(FXP_MUL) = 10, derived localparam.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 valid_in  input  1  upstream matrix valid.
REQ-006 ready_out  output  1  block can accept a matrix.
REQ-007 c1, c2, c3, c4  input  [3:0][2W-1:0] each  result columns, signed 2W:2FRAC, index = row.
REQ-008 valid_out  output  1  c_out holds a valid element.
REQ-009 ready_in  input  1  downstream accepts c_out.
REQ-010 c_out  output  W  serialized element, signed W:FRAC.
REQ-011 last_out  output  1  high with the 16th element of a matrix.

Function
REQ-012 The block SHALL be the serializing counterpart of the 4x4 input buffer: parallel 4x4 in, one element per handshake out.
REQ-013 States SHALL be IDLE and STREAM only.
REQ-014 IDLE: ready_out=1, valid_out=0; edge with valid_in=1 SHALL capture all 16 elements, set ready_out=0, go STREAM.
REQ-015 Capture edge SHALL also load c_out=conv(c1[0]), valid_out=1, last_out=0, element index=1 (first beat latency 1 cycle).
REQ-016 Order SHALL be column-major: beat k carries column k/4+1, row k%4 (c1[0..3], c2[0..3], c3[0..3], c4[0..3]).
REQ-017 Beat handshake = valid_out && ready_in at a rising edge; without it c_out, last_out, valid_out SHALL hold stable.
REQ-018 Handshake with last_out=0 SHALL load next element, last_out=1 when loading beat 15, index increments.
REQ-019 Handshake with last_out=1 SHALL clear valid_out and last_out, set ready_out=1, return to IDLE.
REQ-020 valid_in during STREAM SHALL be ignored; captured data SHALL NOT change until IDLE.
REQ-021 Minimum matrix period SHALL be 17 cycles (1 accept + 16 beats, ready_in held high).
REQ-022 conv: arithmetic shift right by FRAC (floor toward -inf), then narrowing to W bits per REQ-027.
REQ-023 All outputs SHALL be registered.

Reset
REQ-024 rst_n low SHALL immediately force: state IDLE, index 0, captured matrix 0, c_out 0, valid_out 0, last_out 0, ready_out 0.
REQ-025 First rising edge with rst_n high SHALL set ready_out=1; no valid_in captured on that edge.
REQ-026 Reset mid-stream SHALL discard remaining beats; no partial matrix resumes.

Configuration
REQ-027 Macro MATRIX_SER_SAT_EN defined: shifted value SHALL clamp to [-2^(W-1), 2^(W-1)-1] (0x800..0x7FF for W=12); undefined: SHALL keep low W bits (two's-complement wrap).

Structure
REQ-028 Package matrix_pkg SHALL hold W, FXP_MUL, FRAC defaults, elem_t (W), acc_t (2W), column type [3:0] acc_t, ser state enum.
REQ-029 Sub-module fxp_narrow (combinational acc_t -> elem_t, contains MATRIX_SER_SAT_EN logic) SHALL implement conv.

Verification
REQ-030 Identity-scaled: column k row r = (4k+r+1)<<20, ready_in=1 -> c_out 0x400,0x800,... sequence 1..16 scaled by 1024 wrapped, last_out only on beat 16, 17-cycle period.
REQ-031 Negative: c1[0]=0xF80000 (-0.5) -> c_out=0xE00 (-512) on first beat.
REQ-032 Overflow: c1[0]=0x400000 (4.0) -> 0x7FF with MATRIX_SER_SAT_EN, 0x000 without; c1[1]=0xC00000 (-4.0) -> 0x800 / 0x000.
REQ-033 Backpressure: ready_in low cycles 3-7 of stream -> c_out/last_out stable, no beat lost or duplicated, 16 beats total.
REQ-034 Reset after 5 beats -> valid_out 0 asynchronously, ready_out 1 one edge after release, next matrix streams from c1[0].
REQ-035 valid_in held high during STREAM with changing c1..c4 -> output equals matrix captured at accept edge.
